// File: rtl/alu_seq_if.sv
// Bus-side signal bundle for the multi-cycle ALU stage: operand loads, control,
// the tri-stated result bus and the flag/status outputs.
interface alu_seq_if;
    logic [15:0] bin;
    logic        lda;
    logic        ldb;
    logic        start;
    logic [2:0]  op;
    logic        tres;
    wire  [15:0] bus;
    logic [15:0] result;
    logic        c;
    logic        c2;
    logic        busy;
    logic        done;
    logic        sflag;

    modport master (
        output bin, lda, ldb, start, op, tres,
        input  bus, result, c, c2, busy, done, sflag
    );

    modport slave (
        input  bin, lda, ldb, start, op, tres,
        output bus, result, c, c2, busy, done, sflag
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle 16-bit ALU stage: single-cycle logic/arithmetic, iterative left
// shift and 16-step shift-add multiply, result tri-stated back onto the bus.
module alu_seq (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave ifc
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] a, b, w, m, r;
    logic [31:0] p, p_nxt;
    logic [4:0]  n;
    logic [2:0]  opr;
    logic        c, c2, sc;
    logic [17:0] sum;

    // Returns {carry out, carry into bit 15, sum}; subtraction is x + ~y + 1.
    function automatic logic [17:0] add_sub(input logic [15:0] x, input logic [15:0] y,
                                            input logic sub);
        logic [15:0] yy;
        logic [16:0] s;
        yy = sub ? ~y : y;
        s  = {1'b0, x} + {1'b0, yy} + {16'd0, sub};
        return {s[16], s[15] ^ x[15] ^ yy[15], s[15:0]};
    endfunction

    assign sum   = add_sub(w, m, opr == OP_SUB);
    assign p_nxt = m[0] ? p + ({16'd0, w} << n) : p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ifc.start) begin
                    if (ifc.op == OP_SHL)      state_nxt = S_SHIFT;
                    else if (ifc.op == OP_MUL) state_nxt = S_MUL;
                    else                       state_nxt = S_EXEC;
                end
            end
            S_EXEC:  state_nxt = S_DONE;
            S_SHIFT: if (n == 5'd0) state_nxt = S_DONE;
            S_MUL:   if (n == 5'd15) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand registers load in every state; an in-flight op works from W/M only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a <= 16'd0;
            b <= 16'd0;
        end else begin
            if (ifc.lda) a <= ifc.bin;
            if (ifc.ldb) b <= ifc.bin;
        end
    end

    // sc tracks the last bit shifted out so c stays stable until the shift completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w   <= 16'd0;
            m   <= 16'd0;
            p   <= 32'd0;
            n   <= 5'd0;
            opr <= OP_ADD;
            r   <= 16'd0;
            c   <= 1'b0;
            c2  <= 1'b0;
            sc  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ifc.start) begin
                        opr <= ifc.op;
                        w   <= a;
                        m   <= b;
                        p   <= 32'd0;
                        sc  <= 1'b0;
                        n   <= (ifc.op == OP_SHL) ? {1'b0, b[3:0]} : 5'd0;
                    end
                end
                S_EXEC: begin
                    c  <= 1'b0;
                    c2 <= 1'b0;
                    case (opr)
                        OP_ADD, OP_SUB: {c, c2, r} <= sum;
                        OP_AND:         r <= w & m;
                        OP_OR:          r <= w | m;
                        OP_XOR:         r <= w ^ m;
                        default:        r <= ~w;
                    endcase
                end
                S_SHIFT: begin
                    if (n != 5'd0) begin
                        w  <= w << 1;
                        sc <= w[15];
                        n  <= n - 5'd1;
                    end else begin
                        r  <= w;
                        c  <= sc;
                        c2 <= sc;
                    end
                end
                S_MUL: begin
                    p <= p_nxt;
                    m <= m >> 1;
                    n <= n + 5'd1;
                    if (n == 5'd15) begin
                        r  <= p_nxt[15:0];
                        c  <= |p_nxt[31:16];
                        c2 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ifc.result = r;
    assign ifc.c      = c;
    assign ifc.c2     = c2;
    assign ifc.busy   = (state != S_IDLE);
    assign ifc.done   = (state == S_DONE);
    assign ifc.sflag  = (state == S_DONE);
    assign ifc.bus    = ifc.tres ? r : 16'hzzzz;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expected results, a monitor
// pops and compares on every done pulse, including latency from the start edge.
module tb_alu_seq;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, NOTA = 3'b101, SHL = 3'b110, MUL = 3'b111;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        c2;
        int          lat;
        int          t0;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   issued;
    int   seen;
    exp_t sb[$];

    alu_seq_if ifc ();

    alu_seq dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && ifc.done === 1'b1) begin
            seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", {16'd0, ifc.result}, {16'd0, e.r});
                chk("c", {31'd0, ifc.c}, {31'd0, e.c});
                chk("c2", {31'd0, ifc.c2}, {31'd0, e.c2});
                chk("latency", cyc - e.t0, e.lat);
                chk("sflag", {31'd0, ifc.sflag}, 32'd1);
            end
        end
    end

    task automatic load_a(input logic [15:0] v);
        @(negedge clk);
        ifc.bin = v;
        ifc.lda = 1'b1;
        @(negedge clk);
        ifc.lda = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        @(negedge clk);
        ifc.bin = v;
        ifc.ldb = 1'b1;
        @(negedge clk);
        ifc.ldb = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] o, input logic [15:0] er, input logic ec,
                            input logic ec2, input int lat, input logic with_lda,
                            input logic [15:0] lda_val);
        exp_t e;
        @(negedge clk);
        ifc.op    = o;
        ifc.start = 1'b1;
        if (with_lda) begin
            ifc.bin = lda_val;
            ifc.lda = 1'b1;
        end
        e.r   = er;
        e.c   = ec;
        e.c2  = ec2;
        e.lat = lat;
        e.t0  = cyc + 1;
        sb.push_back(e);
        issued++;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.lda   = 1'b0;
        chk("busy_after_start", {31'd0, ifc.busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (ifc.busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", k);
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                       input logic [15:0] er, input logic ec, input logic ec2, input int lat);
        load_a(a);
        load_b(b);
        start_op(o, er, ec, ec2, lat, 1'b0, 16'd0);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        issued    = 0;
        seen      = 0;
        reset     = 1'b0;
        ifc.bin   = 16'd0;
        ifc.lda   = 1'b0;
        ifc.ldb   = 1'b0;
        ifc.start = 1'b0;
        ifc.op    = ADD;
        ifc.tres  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_done", {31'd0, ifc.done}, 32'd0);
        chk("rst_sflag", {31'd0, ifc.sflag}, 32'd0);
        chk("rst_result", {16'd0, ifc.result}, 32'd0);
        chk("rst_c", {30'd0, ifc.c, ifc.c2}, 32'd0);
        chk("rst_bus", {16'd0, ifc.bus}, 32'd0);
        ifc.tres = 1'b0;
        reset    = 1'b1;

        run(16'h7FFF, 16'h0001, ADD,  16'h8000, 1'b0, 1'b1, 1);
        run(16'h0005, 16'h0007, SUB,  16'hFFFE, 1'b0, 1'b0, 1);
        run(16'h0007, 16'h0005, SUB,  16'h0002, 1'b1, 1'b1, 1);
        run(16'hF0F0, 16'h3C3C, AND_, 16'h3030, 1'b0, 1'b0, 1);
        run(16'hF0F0, 16'h3C3C, OR_,  16'hFCFC, 1'b0, 1'b0, 1);
        run(16'hF0F0, 16'h3C3C, XOR_, 16'hCCCC, 1'b0, 1'b0, 1);
        run(16'hF0F0, 16'h3C3C, NOTA, 16'h0F0F, 1'b0, 1'b0, 1);
        run(16'h8001, 16'h0004, SHL,  16'h0010, 1'b0, 1'b0, 5);
        run(16'h8001, 16'h0001, SHL,  16'h0002, 1'b1, 1'b1, 2);
        run(16'h8001, 16'h0000, SHL,  16'h8001, 1'b0, 1'b0, 1);
        run(16'h0003, 16'h000F, SHL,  16'h8000, 1'b1, 1'b1, 16);
        run(16'h0003, 16'h0005, MUL,  16'h000F, 1'b0, 1'b0, 16);
        run(16'h0100, 16'h0100, MUL,  16'h0000, 1'b1, 1'b0, 16);
        run(16'hFFFF, 16'hFFFF, MUL,  16'h0001, 1'b1, 1'b0, 16);

        // Abort a multiply after 8 iterations; previous R=0x0001, c=1.
        load_a(16'h0003);
        load_b(16'h0005);
        start_op(MUL, 16'h000F, 1'b0, 1'b0, 16, 1'b0, 16'd0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
        chk("abort_result", {16'd0, ifc.result}, 32'd0);
        chk("abort_c", {31'd0, ifc.c}, 32'd0);
        chk("abort_done", {31'd0, ifc.done}, 32'd0);
        sb.delete();
        issued--;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        run(16'h0001, 16'h0001, ADD, 16'h0002, 1'b0, 1'b0, 1);

        // start pulsed mid-multiply must be ignored.
        load_a(16'h0003);
        load_b(16'h0005);
        start_op(MUL, 16'h000F, 1'b0, 1'b0, 16, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        ifc.op    = ADD;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_idle();

        // lda mid-op leaves the multiply intact; next op sees the new A.
        load_a(16'h0003);
        load_b(16'h0005);
        start_op(MUL, 16'h000F, 1'b0, 1'b0, 16, 1'b0, 16'd0);
        repeat (4) @(negedge clk);
        ifc.bin = 16'h1234;
        ifc.lda = 1'b1;
        @(negedge clk);
        ifc.lda = 1'b0;
        wait_idle();
        start_op(ADD, 16'h1239, 1'b0, 1'b0, 1, 1'b0, 16'd0);
        wait_idle();

        // lda on the start edge: the op uses the old A, the next op the new one.
        start_op(ADD, 16'h1239, 1'b0, 1'b0, 1, 1'b1, 16'h0001);
        wait_idle();
        start_op(ADD, 16'h0006, 1'b0, 1'b0, 1, 1'b0, 16'd0);
        wait_idle();

        ifc.tres = 1'b1;
        #1;
        chk("bus_driven", {16'd0, ifc.bus}, 32'h0006);
        ifc.tres = 1'b0;
        #1;
        chk("bus_released", {31'd0, (ifc.bus !== 16'h0006)}, 32'd1);

        repeat (3) @(negedge clk);
        chk("done_count", seen, issued);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
